// File: rtl/ym_dbg_pkg.sv
// Shared definitions for the debug read-chain capture block.
//   YM_DBG_MAX_CHAIN : largest supported chain length (bits)
//   dbg_state_e      : capture sequencer states
package ym_dbg_pkg;
  localparam int YM_DBG_MAX_CHAIN = 256;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    SMP  = 3'd3,
    DONE = 3'd4
  } dbg_state_e;
endpackage

// File: rtl/ym_dbg_shift_in.sv
// LSB-first serial-to-parallel deserialiser.
//   MCLK     : clock
//   rst_n    : async active-low clear of the word
//   shift_en : shift din in at the MSB end this cycle
//   din      : serial input bit
//   word     : assembled word; first bit shifted in ends up at bit 0
module ym_dbg_shift_in #(
  parameter int W = 16
) (
  input  logic         MCLK,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] word
);
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n)        word <= '0;
    else if (shift_en) word <= {din, word[W-1:1]};
  end
endmodule

// File: rtl/ym_dbg_capture.sv
// Host-side receiver for the serial debug read chain. Drives the phase
// strobes and the parallel-load pulse, deserialises the chain tail and
// offers the captured word on a valid/ready handshake.
//   MCLK, rst_n         : clock, async active-low reset
//   start, abort        : begin / cancel a capture
//   busy                : capture or delivery in progress
//   dbg_c1, dbg_c2      : chain phase enables
//   dbg_load            : chain parallel-load select (first PH1 only)
//   dbg_prev            : chain head serial input (tied 0)
//   dbg_next            : chain tail serial output
//   out_data/valid/ready: captured word handshake
module ym_dbg_capture
  import ym_dbg_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 MCLK,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 dbg_c1,
  output logic                 dbg_c2,
  output logic                 dbg_load,
  output logic                 dbg_prev,
  input  logic                 dbg_next,
  output logic [CHAIN_LEN-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int CW = $clog2(CHAIN_LEN);

  if (CHAIN_LEN < 2 || CHAIN_LEN > YM_DBG_MAX_CHAIN) begin : g_bad_len
    $error("ym_dbg_capture: CHAIN_LEN out of range");
  end

  dbg_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          last_bit;
  logic          shift_en;

  assign last_bit = (cnt_q == CW'(CHAIN_LEN - 1));
  assign dbg_prev = 1'b0;

  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Count is zeroed while idle so every capture starts at bit 0; it stops
  // at the last bit instead of wrapping.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n)                            cnt_q <= '0;
    else if (state_q == IDLE)              cnt_q <= '0;
    else if (state_q == SMP && !last_bit)  cnt_q <= cnt_q + CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    dbg_c1    = 1'b0;
    dbg_c2    = 1'b0;
    dbg_load  = 1'b0;
    out_valid = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) state_d = PH1;
      end
      PH1: begin
        dbg_c1   = 1'b1;
        dbg_load = (cnt_q == '0);
        state_d  = abort ? IDLE : PH2;
      end
      PH2: begin
        dbg_c2  = 1'b1;
        state_d = abort ? IDLE : SMP;
      end
      SMP: begin
        shift_en = 1'b1;
        if (abort)         state_d = IDLE;
        else if (last_bit) state_d = DONE;
        else               state_d = PH1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  ym_dbg_shift_in #(.W(CHAIN_LEN)) u_shift (
    .MCLK     (MCLK),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (dbg_next),
    .word     (out_data)
  );
endmodule

// File: tb/tb_ym_dbg_capture.sv
// Bench for ym_dbg_capture: behavioural chain model on the dbg_* pins,
// a cycle-phase reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_ym_dbg_capture;
  localparam int N    = 8;
  localparam int LAST = 3 * N;

  logic MCLK = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic busy, dbg_c1, dbg_c2, dbg_load, dbg_prev, dbg_next, out_valid;
  logic [N-1:0] out_data;

  logic start2 = 1'b0;
  logic busy2, c1_2, c2_2, load2, prev2, next2, valid2;
  logic [1:0] data2;

  logic [N-1:0] load_val = '0;
  logic [N-1:0] sh  = '0;
  logic [1:0]   sh2 = '0;

  int tests = 0;
  int errs  = 0;

  always #5 MCLK = ~MCLK;

  ym_dbg_capture #(.CHAIN_LEN(N)) dut (
    .MCLK(MCLK), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .dbg_c1(dbg_c1), .dbg_c2(dbg_c2), .dbg_load(dbg_load), .dbg_prev(dbg_prev),
    .dbg_next(dbg_next), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready));

  ym_dbg_capture #(.CHAIN_LEN(2)) dut2 (
    .MCLK(MCLK), .rst_n(rst_n), .start(start2), .abort(1'b0), .busy(busy2),
    .dbg_c1(c1_2), .dbg_c2(c2_2), .dbg_load(load2), .dbg_prev(prev2),
    .dbg_next(next2), .out_data(data2), .out_valid(valid2),
    .out_ready(1'b1));

  // Chain of read stages: loads on a c1 phase with load set, otherwise a c1
  // phase advances the chain by one toward the tail.
  always @(posedge MCLK) begin
    if (dbg_c1) sh <= dbg_load ? load_val : {dbg_prev, sh[N-1:1]};
    if (c1_2)   sh2 <= load2 ? 2'b10 : {prev2, sh2[1]};
  end
  assign dbg_next = sh[0];
  assign next2    = sh2[0];

  // Reference: a capture is a count of cycles since the accepted start.
  // Phases 1..3N sweep the chain (c1 on phase%3==1, c2 on phase%3==2),
  // phase 3N+1 holds the word until it is taken.
  logic         m_act;
  int           m_ph;
  logic [N-1:0] m_word;

  always @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_ph  <= 0;
    end else if (!m_act) begin
      if (start && !abort) begin
        m_act  <= 1'b1;
        m_ph   <= 1;
        m_word <= load_val;
      end
    end else if (m_ph <= LAST) begin
      if (abort) m_act <= 1'b0;
      else       m_ph  <= m_ph + 1;
    end else if (out_ready) begin
      m_act <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge MCLK) begin
    logic sweep, vexp;
    sweep = m_act && (m_ph <= LAST);
    vexp  = m_act && (m_ph > LAST);
    chk("m_busy",  busy,      m_act);
    chk("m_valid", out_valid, vexp);
    chk("m_c1",    dbg_c1,    sweep && (m_ph % 3 == 1));
    chk("m_c2",    dbg_c2,    sweep && (m_ph % 3 == 2));
    chk("m_load",  dbg_load,  m_act && (m_ph == 1));
    chk("m_prev",  dbg_prev,  1'b0);
    if (vexp) chk("m_data", out_data, m_word);
    chk("c1c2_excl",  dbg_c1 & dbg_c2, 1'b0);
    chk("c1c2_excl2", c1_2 & c2_2,     1'b0);
  end

  task automatic wait_valid(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge MCLK);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) chk(nm, 32'd0, 32'd1);
  endtask

  initial begin
    int vk, nload;
    bit vseen;

    // Reset state
    #3;
    chk("rst_busy", busy, 0);      chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);  chk("rst_c1", dbg_c1, 0);
    chk("rst_c2", dbg_c2, 0);      chk("rst_load", dbg_load, 0);
    @(posedge MCLK); #1 rst_n = 1'b1;
    @(posedge MCLK); #1;

    // A: 0xA5 with ready held high
    load_val = 8'hA5; out_ready = 1'b1; start = 1'b1;
    vk = 0; nload = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge MCLK); #1 start = 1'b0;
      @(negedge MCLK);
      if (dbg_load) nload++;
      if (k == 1) chk("A_load_c1", dbg_load, 1);
      if (out_valid && vk == 0) begin
        vk = k;
        chk("A_data", out_data, 8'hA5);
      end
      if (k == 26) chk("A_busy_c26", busy, 0);
    end
    chk("A_valid_cycle", vk, 25);
    chk("A_load_count", nload, 1);

    // B: consumer stalls 10 cycles; start during the stall is ignored
    out_ready = 1'b0; start = 1'b1;
    @(posedge MCLK); #1 start = 1'b0;
    wait_valid("B_timeout");
    for (int w = 0; w < 10; w++) begin
      @(posedge MCLK); #1 start = (w == 3);
      @(negedge MCLK);
      chk("B_hold_data", out_data, 8'hA5);
      chk("B_hold_valid", out_valid, 1);
    end
    start = 1'b0; out_ready = 1'b1;
    @(posedge MCLK); #1;
    chk("B_after_busy", busy, 0);
    @(posedge MCLK); #1;
    chk("B_start_ignored", busy, 0);

    // C: abort in cycle 10, then a clean 0x3C capture
    start = 1'b1; vseen = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge MCLK); #1 start = 1'b0; abort = (k == 10);
      @(negedge MCLK);
      if (out_valid) vseen = 1'b1;
      if (k == 11) chk("C_idle_c11", busy, 0);
    end
    chk("C_no_valid", vseen, 0);
    load_val = 8'h3C; start = 1'b1;
    @(posedge MCLK); #1 start = 1'b0;
    wait_valid("C_timeout");
    chk("C_data", out_data, 8'h3C);
    @(posedge MCLK); #1;

    // D: async reset in the middle of PH2
    start = 1'b1;
    @(posedge MCLK); #1 start = 1'b0;
    @(posedge MCLK); #2;
    chk("D_in_ph2", dbg_c2, 1);
    rst_n = 1'b0; #1;
    chk("D_busy", busy, 0);     chk("D_c2", dbg_c2, 0);
    chk("D_c1", dbg_c1, 0);     chk("D_load", dbg_load, 0);
    chk("D_valid", out_valid, 0); chk("D_data", out_data, 0);
    @(posedge MCLK); #1 rst_n = 1'b1;
    load_val = 8'hFF; start = 1'b1;
    @(posedge MCLK); #1 start = 1'b0;
    wait_valid("D_timeout");
    chk("D_data_ff", out_data, 8'hFF);
    @(posedge MCLK); #1;

    // E: start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge MCLK); #1 start = 1'b0; abort = 1'b0;
    chk("E_busy", busy, 0);
    @(posedge MCLK); #1;
    chk("E_busy2", busy, 0);

    // F: two-bit chain loaded with 2'b10
    start2 = 1'b1; vk = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge MCLK); #1 start2 = 1'b0;
      @(negedge MCLK);
      if (valid2 && vk == 0) begin
        vk = k;
        chk("F_data", data2, 2'b10);
      end
    end
    chk("F_valid_cycle", vk, 7);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge MCLK); #1;
      if (!m_act) load_val = N'($urandom);
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 60) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge MCLK);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
